rom_tf_fetch_ctrl: RTL

//  Sequences twiddle-factor reads from the 8 dual-packed twiddle ROM banks (b0b1..b14b15) for one FFT stage.
//  All banks share one address; each read returns 16 twiddles, which the downstream ROM-Q decompose splits.

---
 rtl/rom_tf_fetch_ctrl_if.sv | 27 ++
 rtl/rom_tf_fetch_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/rom_tf_fetch_ctrl_if.sv
// Handshake bundle between the stage scheduler / twiddle consumer (master)
// and the twiddle ROM fetch controller (slave).
interface rom_tf_fetch_ctrl_if #(
    parameter int ADDR_W  = 12,
    parameter int STAGE_W = 2
);
    logic               start;
    logic [STAGE_W-1:0] cfg_stage;
    logic [ADDR_W:0]    cfg_len;
    logic [ADDR_W-1:0]  rom_addr;
    logic               rom_cen;
    logic               tf_valid;
    logic               tf_ready;
    logic [ADDR_W-1:0]  tf_idx;
    logic               busy;
    logic               done;

    modport master (
        output start, cfg_stage, cfg_len, tf_ready,
        input  rom_addr, rom_cen, tf_valid, tf_idx, busy, done
    );

    modport slave (
        input  start, cfg_stage, cfg_len, tf_ready,
        output rom_addr, rom_cen, tf_valid, tf_idx, busy, done
    );
endinterface

// File: rtl/rom_tf_fetch_ctrl.sv
// Twiddle ROM fetch sequencer for one FFT stage: shared bank address, chip enable, valid/ready beat stream.
// Optional build macro ROM_CEN_GATE_EN: chip enable asserted only in issuing cycles.
module rom_tf_fetch_ctrl #(
    parameter int ADDR_W      = 12,
    parameter int STAGE_W     = 2,
    parameter int STRIDE_LOG2 = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rom_tf_fetch_ctrl_if.slave   bus
);
    localparam int SH_MAX = STRIDE_LOG2 * ((1 << STAGE_W) - 1);
    localparam int SH_W   = (SH_MAX < 2) ? 1 : $clog2(SH_MAX + 1);
    localparam logic [ADDR_W:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W:0]    cnt;
    logic [ADDR_W:0]    len;
    logic [STAGE_W-1:0] stage;
    logic [ADDR_W-1:0]  rom_addr;
    logic [ADDR_W-1:0]  tf_idx;
    logic               tf_valid;
    logic               done;
    logic               busy;
    logic               rom_cen;

    logic               issue;
    logic               accept;
    logic               last;
    logic [SH_W-1:0]    shamt;
    logic [ADDR_W:0]    cnt_inc;
    logic [ADDR_W:0]    addr_wide;
    logic [ADDR_W-1:0]  addr_nxt;

    assign accept    = tf_valid & bus.tf_ready;
    assign issue     = (state == FETCH) & (~tf_valid | bus.tf_ready);
    assign last      = (cnt == len - ONE);
    assign shamt     = SH_W'(STRIDE_LOG2) * SH_W'(stage);
    assign cnt_inc   = cnt + ONE;
    // Bits shifted past ADDR_W are dropped: large strides wrap the address silently.
    assign addr_wide = cnt_inc << shamt;
    assign addr_nxt  = addr_wide[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start && (bus.cfg_len != '0)) state_nxt = FETCH;
            FETCH:   if (issue && last)                    state_nxt = DRAIN;
            DRAIN:   if (accept)                           state_nxt = IDLE;
            default:                                       state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
`ifdef ROM_CEN_GATE_EN
        rom_cen = ~issue;
`else
        rom_cen = ~busy;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            len      <= '0;
            stage    <= '0;
            rom_addr <= '0;
            tf_idx   <= '0;
            tf_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept && !issue) tf_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.cfg_len != '0) begin
                            stage    <= bus.cfg_stage;
                            len      <= bus.cfg_len;
                            cnt      <= '0;
                            rom_addr <= '0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (issue) begin
                        tf_valid <= 1'b1;
                        tf_idx   <= cnt[ADDR_W-1:0];
                        if (!last) begin
                            cnt      <= cnt_inc;
                            rom_addr <= addr_nxt;
                        end
                    end
                end
                DRAIN: begin
                    // done is registered with the return to IDLE, so it shows in the first IDLE cycle.
                    if (accept) done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.rom_addr = rom_addr;
    assign bus.rom_cen  = rom_cen;
    assign bus.tf_valid = tf_valid;
    assign bus.tf_idx   = tf_idx;
    assign bus.busy     = busy;
    assign bus.done     = done;
endmodule
